// File: rtl/psum_bias_init_unit.sv
// psum_bias_init_unit
//   Per-lane source selector that seeds the partial-sum accumulators at the
//   start of an accumulation pass. Each accepted beat picks, for every lane,
//   one of: raw psum, FC feedback, fixed-point-aligned bias, or psum+bias.
//   Biases come from an internal row table indexed by an auto-advancing
//   channel counter. One-deep valid/ready output register, 1-cycle latency.
//
//   Optional feature macro: PSUM_SAT_EN
//     defined   -> sel=3 saturates per lane and reports sat_flag
//     undefined -> sel=3 wraps modulo 2^PSUM_WID, sat_flag stays 0
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   bias_wr_en     write one bias-table row
//   bias_wr_addr   row to write
//   bias_wr_data   row data, lane l at [l*BIAS_WID +: BIAS_WID]
//   cfg_num_ch     number of active rows (1..BIAS_DEPTH)
//   ch_clear       force channel counter to 0
//   in_valid       input beat valid
//   in_ready       block can accept a beat (combinational)
//   sel            0 psum, 1 fc_reg, 2 bias, 3 psum+bias
//   psum           psum per lane
//   fc_reg         FC feedback per lane
//   out_valid      output beat valid
//   out_ready      downstream accepts
//   data_out       selected value per lane
//   ch_idx         current channel counter
//   sat_flag       per-lane saturation indicator for the current output beat
module psum_bias_init_unit #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned PSUM_WID   = 32,
  parameter int unsigned BIAS_WID   = 16,
  parameter int unsigned FRAC_SHIFT = 8,
  parameter int unsigned BIAS_DEPTH = 16,
  parameter int unsigned CH_W       = $clog2(BIAS_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bias_wr_en,
  input  logic [CH_W-1:0]           bias_wr_addr,
  input  logic [LANES*BIAS_WID-1:0] bias_wr_data,
  input  logic [CH_W:0]             cfg_num_ch,
  input  logic                      ch_clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                sel,
  input  logic [LANES*PSUM_WID-1:0] psum,
  input  logic [LANES*PSUM_WID-1:0] fc_reg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*PSUM_WID-1:0] data_out,
  output logic [CH_W-1:0]           ch_idx,
  output logic [LANES-1:0]          sat_flag
);

  localparam int unsigned ROW_W = LANES * BIAS_WID;

  localparam logic [1:0] SEL_PSUM = 2'd0;
  localparam logic [1:0] SEL_FC   = 2'd1;
  localparam logic [1:0] SEL_BIAS = 2'd2;
  localparam logic [1:0] SEL_SUM  = 2'd3;

  logic [ROW_W-1:0]          bias_table [BIAS_DEPTH];
  logic [ROW_W-1:0]          bias_row_c;
  logic                      accept_c;
  logic                      bias_beat_c;
  logic                      ch_wrap_c;
  logic [PSUM_WID-1:0]       lane_data_c [LANES];
  logic                      lane_sat_c  [LANES];
  logic [LANES*PSUM_WID-1:0] nxt_data_c;
  logic [LANES-1:0]          nxt_sat_c;

  // Handshake: the output register can take a new beat when empty or draining.
  assign in_ready    = !out_valid || out_ready;
  assign accept_c    = in_valid && in_ready;
  assign bias_beat_c = accept_c && sel[1];

  // Table read is from the registered array, so a same-cycle write is not seen.
  assign bias_row_c = bias_table[ch_idx];

  // Bias table storage; reset clears every row.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < int'(BIAS_DEPTH); r++) begin
        bias_table[r] <= '0;
      end
    end else if (bias_wr_en && (int'(bias_wr_addr) < int'(BIAS_DEPTH))) begin
      bias_table[bias_wr_addr] <= bias_wr_data;
    end
  end

  // Wrap point of the channel counter; an illegal cfg_num_ch=0 uses the full table.
  always_comb begin
    ch_wrap_c = 1'b0;
    if (cfg_num_ch == '0) begin
      ch_wrap_c = (ch_idx == CH_W'(BIAS_DEPTH - 1));
    end else begin
      ch_wrap_c = ({1'b0, ch_idx} == (cfg_num_ch - (CH_W+1)'(1)));
    end
  end

  // Channel counter: clear wins over advance; only bias-using beats advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_idx <= '0;
    end else if (ch_clear) begin
      ch_idx <= '0;
    end else if (bias_beat_c) begin
      ch_idx <= ch_wrap_c ? '0 : (ch_idx + CH_W'(1));
    end
  end

  // Per-lane datapath: bias alignment, optional add, source select.
  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    logic [BIAS_WID-1:0]        bias_w;
    logic signed [BIAS_WID-1:0] bias_s;
    logic [PSUM_WID-1:0]        bext;
    logic [PSUM_WID-1:0]        psum_w;
    logic [PSUM_WID-1:0]        fc_w;
    logic [PSUM_WID-1:0]        sum_w;
    logic                       sum_sat;
    logic [PSUM_WID-1:0]        sum_res;

    assign bias_w = bias_row_c[l*BIAS_WID +: BIAS_WID];
    assign bias_s = $signed(bias_w);
    // Sign-extend to full width, then shift into the psum fixed-point position.
    assign bext   = PSUM_WID'(bias_s) << FRAC_SHIFT;
    assign psum_w = psum[l*PSUM_WID +: PSUM_WID];
    assign fc_w   = fc_reg[l*PSUM_WID +: PSUM_WID];
    assign sum_w  = psum_w + bext;

`ifdef PSUM_SAT_EN
    logic pos_ovf;
    logic neg_ovf;

    // Overflow only when both operands share a sign the result does not.
    assign pos_ovf = !psum_w[PSUM_WID-1] && !bext[PSUM_WID-1] &&  sum_w[PSUM_WID-1];
    assign neg_ovf =  psum_w[PSUM_WID-1] &&  bext[PSUM_WID-1] && !sum_w[PSUM_WID-1];

    always_comb begin
      sum_res = sum_w;
      sum_sat = 1'b0;
      if (pos_ovf) begin
        sum_res = {1'b0, {(PSUM_WID-1){1'b1}}};
        sum_sat = 1'b1;
      end else if (neg_ovf) begin
        sum_res = {1'b1, {(PSUM_WID-1){1'b0}}};
        sum_sat = 1'b1;
      end
    end
`else
    assign sum_res = sum_w;
    assign sum_sat = 1'b0;
`endif

    // Source select; only the psum+bias path may raise the saturation flag.
    always_comb begin
      lane_data_c[l] = psum_w;
      lane_sat_c[l]  = 1'b0;
      case (sel)
        SEL_PSUM: lane_data_c[l] = psum_w;
        SEL_FC:   lane_data_c[l] = fc_w;
        SEL_BIAS: lane_data_c[l] = bext;
        SEL_SUM: begin
          lane_data_c[l] = sum_res;
          lane_sat_c[l]  = sum_sat;
        end
        default:  lane_data_c[l] = psum_w;
      endcase
    end
  end

  // Pack per-lane results into the output bus layout.
  always_comb begin
    nxt_data_c = '0;
    nxt_sat_c  = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      nxt_data_c[l*PSUM_WID +: PSUM_WID] = lane_data_c[l];
      nxt_sat_c[l]                       = lane_sat_c[l];
    end
  end

  // One-deep output register; holds while stalled, empties when drained.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_flag  <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      data_out  <= nxt_data_c;
      sat_flag  <= nxt_sat_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_bias_init_unit.sv
// Self-checking bench for psum_bias_init_unit (default parameters).
// Directed scenarios check hand-derived constants; a randomized phase checks
// every cycle against an arithmetic reference model kept in this file.
module tb_psum_bias_init_unit;

  localparam int LANES = 4;
  localparam int PW    = 32;
  localparam int BW    = 16;
  localparam int FS    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 4;

  logic                  clk;
  logic                  rst;
  logic                  bias_wr_en;
  logic [CW-1:0]         bias_wr_addr;
  logic [LANES*BW-1:0]   bias_wr_data;
  logic [CW:0]           cfg_num_ch;
  logic                  ch_clear;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            sel;
  logic [LANES*PW-1:0]   psum;
  logic [LANES*PW-1:0]   fc_reg;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*PW-1:0]   data_out;
  logic [CW-1:0]         ch_idx;
  logic [LANES-1:0]      sat_flag;

  int total;
  int bad;

  // Reference model state
  logic          m_valid;
  logic [PW-1:0] m_data [LANES];
  logic          m_sat  [LANES];
  int            m_ch;
  logic [BW-1:0] m_tab  [DEPTH][LANES];

  psum_bias_init_unit dut (
    .clk          (clk),
    .rst          (rst),
    .bias_wr_en   (bias_wr_en),
    .bias_wr_addr (bias_wr_addr),
    .bias_wr_data (bias_wr_data),
    .cfg_num_ch   (cfg_num_ch),
    .ch_clear     (ch_clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sel          (sel),
    .psum         (psum),
    .fc_reg       (fc_reg),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .ch_idx       (ch_idx),
    .sat_flag     (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lane value from plain signed arithmetic on the source operands.
  task automatic ref_lane(input logic [1:0] s, input logic [PW-1:0] p, input logic [PW-1:0] f,
                          input logic [BW-1:0] b, output logic [PW-1:0] v, output logic sat);
    longint bx;
    longint sm;
    bx  = longint'($signed(b)) * (longint'(1) << FS);
    sat = 1'b0;
    v   = p;
    case (s)
      2'd0: v = p;
      2'd1: v = f;
      2'd2: v = 32'(bx);
      default: begin
        sm = longint'($signed(p)) + bx;
`ifdef PSUM_SAT_EN
        if (sm > 64'sd2147483647) begin
          v = 32'h7FFF_FFFF; sat = 1'b1;
        end else if (sm < -64'sd2147483648) begin
          v = 32'h8000_0000; sat = 1'b1;
        end else begin
          v = 32'(sm);
        end
`else
        v = 32'(sm);
`endif
      end
    endcase
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic          rdy;
    logic          acc;
    logic [PW-1:0] v;
    logic          s;
    int            n;
    if (!rst) begin
      m_valid = 1'b0;
      m_ch    = 0;
      for (int l = 0; l < LANES; l++) begin
        m_data[l] = '0;
        m_sat[l]  = 1'b0;
      end
      for (int r = 0; r < DEPTH; r++)
        for (int l = 0; l < LANES; l++) m_tab[r][l] = '0;
    end else begin
      rdy = !m_valid || out_ready;
      acc = in_valid && rdy;
      if (acc) begin
        for (int l = 0; l < LANES; l++) begin
          ref_lane(sel, psum[l*PW +: PW], fc_reg[l*PW +: PW], m_tab[m_ch][l], v, s);
          m_data[l] = v;
          m_sat[l]  = s;
        end
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (bias_wr_en)
        for (int l = 0; l < LANES; l++) m_tab[bias_wr_addr][l] = bias_wr_data[l*BW +: BW];
      n = (cfg_num_ch == 0) ? DEPTH : int'(cfg_num_ch);
      if (ch_clear) m_ch = 0;
      else if (acc && sel[1]) m_ch = (m_ch == n - 1) ? 0 : (m_ch + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_row(input int addr, input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                        input logic [BW-1:0] b2, input logic [BW-1:0] b3);
    bias_wr_en   = 1'b1;
    bias_wr_addr = CW'(addr);
    bias_wr_data = {b3, b2, b1, b0};
    tick();
    bias_wr_en   = 1'b0;
  endtask

  task automatic bias_beat(input logic [1:0] s);
    in_valid = 1'b1;
    sel      = s;
    psum     = {$urandom, $urandom, $urandom, $urandom};
    fc_reg   = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data got %h exp 0", data_out); end
    total++; if (sat_flag !== '0) begin bad++; $display("FAIL reset_sat got %b exp 0", sat_flag); end
    total++; if (ch_idx !== '0) begin bad++; $display("FAIL reset_ch_idx got %0d exp 0", ch_idx); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_alignment();
    cfg_num_ch = 5'd16;
    wr_row(0, 16'h8000, 16'h0001, 16'(($urandom)), 16'(($urandom)));
    in_valid = 1'b1; sel = 2'd2; psum = {$urandom, $urandom, $urandom, $urandom};
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL align_pre_valid got %b exp 0", out_valid); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL align_valid got %b exp 1", out_valid); end
    total++; if (data_out[0 +: PW] !== 32'hFF80_0000) begin bad++; $display("FAIL align_lane0 got %h exp ff800000", data_out[0 +: PW]); end
    total++; if (data_out[PW +: PW] !== 32'h0000_0100) begin bad++; $display("FAIL align_lane1 got %h exp 00000100", data_out[PW +: PW]); end
    for (int l = 2; l < LANES; l++) begin
      total++; if (data_out[l*PW +: PW] !== m_data[l]) begin bad++; $display("FAIL align_lane%0d got %h exp %h", l, data_out[l*PW +: PW], m_data[l]); end
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL align_single_beat got %b exp 0", out_valid); end
  endtask

  task automatic test_counter_wrap();
    int            s_tab [6] = '{2, 2, 0, 2, 2, 2};
    int            r_tab [6] = '{0, 1, 0, 2, 0, 1};
    int            c_tab [6] = '{1, 2, 2, 0, 1, 0};
    logic [PW-1:0] exp_v;
    logic [PW-1:0] p0;
    ch_clear = 1'b1; tick(); ch_clear = 1'b0;
    cfg_num_ch = 5'd3;
    for (int r = 0; r < 3; r++) begin
      wr_row(r, 16'(16'h0100 * (r + 1)), 16'(16'h0100 * (r + 1)),
                16'(16'h0100 * (r + 1)), 16'(16'h0100 * (r + 1)));
    end
    for (int i = 0; i < 6; i++) begin
      ch_clear = (i == 5);
      in_valid = 1'b1; sel = 2'(s_tab[i]);
      psum = {$urandom, $urandom, $urandom, $urandom};
      p0 = psum[0 +: PW];
      tick();
      in_valid = 1'b0; ch_clear = 1'b0;
      exp_v = (s_tab[i] == 0) ? p0 : (32'(r_tab[i] + 1) << 16);
      total++; if (data_out[0 +: PW] !== exp_v) begin bad++; $display("FAIL wrap_data%0d got %h exp %h", i, data_out[0 +: PW], exp_v); end
      total++; if (ch_idx !== CW'(c_tab[i])) begin bad++; $display("FAIL wrap_ch%0d got %0d exp %0d", i, ch_idx, c_tab[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [PW-1:0] e0;
    logic [PW-1:0] e1;
    logic [LANES-1:0] es;
    cfg_num_ch = 5'd16;
    ch_clear = 1'b1; tick(); ch_clear = 1'b0;
    wr_row(0, 16'h0001, 16'hFFFF, 16'h0001, 16'h0000);
    in_valid = 1'b1; sel = 2'd3;
    psum = {32'h1234_5678, 32'h7FFF_FE00, 32'h8000_0000, 32'h7FFF_FF00};
    tick();
    in_valid = 1'b0;
`ifdef PSUM_SAT_EN
    e0 = 32'h7FFF_FFFF; e1 = 32'h8000_0000; es = 4'b0011;
`else
    e0 = 32'h8000_0000; e1 = 32'h7FFF_FF00; es = 4'b0000;
`endif
    total++; if (data_out[0 +: PW] !== e0) begin bad++; $display("FAIL sat_pos got %h exp %h", data_out[0 +: PW], e0); end
    total++; if (data_out[PW +: PW] !== e1) begin bad++; $display("FAIL sat_neg got %h exp %h", data_out[PW +: PW], e1); end
    total++; if (data_out[2*PW +: PW] !== 32'h7FFF_FF00) begin bad++; $display("FAIL sat_none got %h exp 7fffff00", data_out[2*PW +: PW]); end
    total++; if (data_out[3*PW +: PW] !== 32'h1234_5678) begin bad++; $display("FAIL sat_zero_bias got %h exp 12345678", data_out[3*PW +: PW]); end
    total++; if (sat_flag !== es) begin bad++; $display("FAIL sat_flag got %b exp %b", sat_flag, es); end
  endtask

  task automatic test_backpressure();
    logic [LANES*PW-1:0] beats [5];
    logic [LANES*PW-1:0] q [$];
    logic [LANES*PW-1:0] held;
    logic [LANES*PW-1:0] front;
    logic                exp_rdy;
    int                  sent;
    int                  got;
    sent = 0; got = 0; held = '0;
    for (int i = 0; i < 5; i++) beats[i] = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1; in_valid = 1'b0; tick();
    for (int c = 0; c < 15; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (sent < 5);
      sel       = 2'd0;
      psum      = beats[(sent < 5) ? sent : 4];
      #1;
      exp_rdy = !m_valid || out_ready;
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL bp_in_ready c%0d got %b exp %b", c, in_ready, exp_rdy); end
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL bp_out_valid c%0d got %b exp %b", c, out_valid, m_valid); end
      if (c == 2) held = data_out;
      if (c == 3 || c == 4) begin
        total++; if (data_out !== held) begin bad++; $display("FAIL bp_hold c%0d got %h exp %h", c, data_out, held); end
      end
      if (m_valid && out_ready) begin
        front = (q.size() > 0) ? q.pop_front() : '0;
        got++;
        total++; if (data_out !== front) begin bad++; $display("FAIL bp_order%0d got %h exp %h", got, data_out, front); end
      end
      if (in_valid && exp_rdy) begin
        q.push_back(beats[sent]);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got !== 5 || sent !== 5) begin bad++; $display("FAIL bp_count got %0d/%0d exp 5/5", got, sent); end
  endtask

  task automatic test_collision();
    cfg_num_ch = 5'd16;
    wr_row(1, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    ch_clear = 1'b1; tick(); ch_clear = 1'b0;
    bias_beat(2'd2);
    bias_wr_en = 1'b1; bias_wr_addr = 4'd1; bias_wr_data = {4{16'h0002}};
    bias_beat(2'd2);
    bias_wr_en = 1'b0;
    total++; if (data_out[0 +: PW] !== 32'h0000_0100) begin bad++; $display("FAIL coll_old got %h exp 00000100", data_out[0 +: PW]); end
    ch_clear = 1'b1; tick(); ch_clear = 1'b0;
    bias_beat(2'd2);
    bias_beat(2'd2);
    total++; if (data_out[3*PW +: PW] !== 32'h0000_0200) begin bad++; $display("FAIL coll_new got %h exp 00000200", data_out[3*PW +: PW]); end
  endtask

  task automatic test_random(input int cfg, input int cycles);
    logic exp_rdy;
    cfg_num_ch = 5'(cfg);
    ch_clear = 1'b1; tick(); ch_clear = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      in_valid     = ($urandom_range(3, 0) != 0);
      out_ready    = ($urandom_range(3, 0) != 0);
      sel          = 2'($urandom_range(3, 0));
      psum         = {$urandom, $urandom, $urandom, $urandom};
      fc_reg       = {$urandom, $urandom, $urandom, $urandom};
      bias_wr_en   = ($urandom_range(3, 0) == 0);
      bias_wr_addr = 4'($urandom_range(DEPTH - 1, 0));
      bias_wr_data = {$urandom, $urandom};
      ch_clear     = ($urandom_range(19, 0) == 0);
      #1;
      exp_rdy = !m_valid || out_ready;
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready c%0d got %b exp %b", c, in_ready, exp_rdy); end
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_out_valid c%0d got %b exp %b", c, out_valid, m_valid); end
      total++; if (ch_idx !== CW'(m_ch)) begin bad++; $display("FAIL rnd_ch_idx c%0d got %0d exp %0d", c, ch_idx, m_ch); end
      for (int l = 0; l < LANES; l++) begin
        total++; if (data_out[l*PW +: PW] !== m_data[l] || sat_flag[l] !== m_sat[l]) begin
          bad++; $display("FAIL rnd_lane%0d c%0d got %h/%b exp %h/%b", l, c, data_out[l*PW +: PW], sat_flag[l], m_data[l], m_sat[l]);
        end
      end
      tick();
    end
    in_valid = 1'b0; bias_wr_en = 1'b0; ch_clear = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_midstream();
    cfg_num_ch = 5'd3;
    wr_row(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    wr_row(1, 16'h5555, 16'h6666, 16'h7777, 16'h0888);
    wr_row(2, 16'h0999, 16'h0AAA, 16'h0BBB, 16'h0CCC);
    ch_clear = 1'b1; tick(); ch_clear = 1'b0;
    out_ready = 1'b0;
    bias_beat(2'd2);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstm_pre_valid got %b exp 1", out_valid); end
    in_valid = 1'b1; sel = 2'd2;
    rst = 1'b0;
    tick();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstm_out_valid got %b exp 0", out_valid); end
    total++; if (ch_idx !== '0) begin bad++; $display("FAIL rstm_ch_idx got %0d exp 0", ch_idx); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL rstm_data got %h exp 0", data_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstm_in_ready got %b exp 1", in_ready); end
    for (int r = 0; r < 3; r++) begin
      bias_beat(2'd2);
      total++; if (out_valid !== 1'b1 || data_out !== '0) begin
        bad++; $display("FAIL rstm_row%0d got %b/%h exp 1/0", r, out_valid, data_out);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    m_valid = 1'b0; m_ch = 0;
    rst = 1'b0; bias_wr_en = 1'b0; bias_wr_addr = '0; bias_wr_data = '0;
    cfg_num_ch = 5'd16; ch_clear = 1'b0; in_valid = 1'b0; sel = 2'd0;
    psum = '0; fc_reg = '0; out_ready = 1'b1;
    test_reset();
    test_alignment();
    test_counter_wrap();
    test_saturation();
    test_backpressure();
    test_collision();
    test_random(5, 400);
    test_random(16, 400);
    test_random(1, 200);
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_bias_init_unit.md
# psum_bias_init_unit

Multi-lane, pipelined source selector that feeds the partial-sum accumulators at the start of each accumulation pass. Each beat selects one of four sources for every lane:
- raw psum
- FC feedback register
- fixed-point-aligned bias
- psum plus bias

Per-channel biases come from an internal bias table, indexed by an auto-advancing channel counter. The block sits between the PE-array psum path and the accumulator bank, with a one-deep valid/ready output register.

## Interface
Parameters:
- LANES, 4: parallel psum lanes per beat.
- PSUM_WID, 32: psum word width.
- BIAS_WID, 16: bias word width, two's complement.
- FRAC_SHIFT, 8: left shift aligning bias to the psum fixed-point format. Requires BIAS_WID+FRAC_SHIFT <= PSUM_WID.
- BIAS_DEPTH, 16: bias table rows; each row holds LANES bias words.
- CH_W, $clog2(BIAS_DEPTH): row index width.

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- bias_wr_en  in  1  write one bias-table row.
- bias_wr_addr  in  CH_W  row to write.
- bias_wr_data  in  LANES*BIAS_WID  row data; lane l occupies bits [l*BIAS_WID +: BIAS_WID].
- cfg_num_ch  in  CH_W+1  number of active rows, 1..BIAS_DEPTH; sampled on every counter advance.
- ch_clear  in  1  force the channel counter to 0.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- sel  in  2  source select: 0 psum, 1 fc_reg, 2 bias, 3 psum+bias.
- psum  in  LANES*PSUM_WID  psum per lane.
- fc_reg  in  LANES*PSUM_WID  FC feedback per lane.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- data_out  out  LANES*PSUM_WID  selected value per lane.
- ch_idx  out  CH_W  current channel counter.
- sat_flag  out  LANES  per-lane saturation indicator for the current output beat.

## Operation
- Bias alignment per lane: bext = {sign-extend(bias, PSUM_WID-BIAS_WID-FRAC_SHIFT bits), bias, FRAC_SHIFT zeros}.
- The bias row used by a beat is bias_table[ch_idx]; lane l uses word l of that row.
- sel=3: each lane computes psum+bext in PSUM_WID bits. Overflow handling is set by the configuration macro.
- A beat is accepted when in_valid && in_ready.
- On an accepted beat with sel[1]=1 (bias used), ch_idx advances: it becomes 0 if ch_idx == cfg_num_ch-1, else ch_idx+1.
- Beats with sel 0/1 do not move ch_idx.
- ch_clear has priority over advance: ch_idx=0 next cycle even if a bias beat is accepted in the same cycle. That beat still uses the pre-clear ch_idx.
- Bias table write versus read in the same cycle to the same row: the read returns the old contents; the write is visible from the next cycle.
- cfg_num_ch=0 is illegal; the counter then wraps only at BIAS_DEPTH-1.

## Timing
- Latency: 1 cycle. A beat accepted at edge N is presented on data_out/out_valid after edge N.
- in_ready = !out_valid || out_ready, combinational. This gives full throughput with no bubbles under continuous out_ready=1.
- While out_valid=1 && out_ready=0, data_out, sat_flag and out_valid hold stable.
- out_valid drops after an edge with out_ready=1 and no new accepted beat.
- Reset (rst=0 at an edge), including mid-stream:
  - out_valid=0, data_out=0, sat_flag=0, ch_idx=0.
  - All bias table rows are cleared to 0.
  - An in-flight beat is discarded.
  - in_ready=1 in the first cycle after reset.

## Configuration
- PSUM_SAT_EN defined: sel=3 saturates per lane.
  - Positive overflow gives 2^(PSUM_WID-1)-1; negative overflow gives -2^(PSUM_WID-1).
  - sat_flag[l]=1 on a saturated lane, registered with data_out.
- PSUM_SAT_EN undefined: sel=3 wraps modulo 2^PSUM_WID, and sat_flag is constant 0.
- Either way, sel 0/1/2 never set sat_flag.

## Test plan
All scenarios use default parameters.
- Alignment: row0 lane0 bias=0x8000, lane1 bias=0x0001; sel=2 → lane0 0xFF800000, lane1 0x00000100; out_valid exactly 1 cycle after accept.
- Counter wrap: cfg_num_ch=3, rows 0..2 loaded with distinct biases; 4 sel=2 beats → rows 0,1,2,0; an interleaved sel=0 beat leaves ch_idx unchanged; ch_clear alongside a bias beat → that beat uses the old row, ch_idx=0 next cycle.
- Saturation: psum=0x7FFFFF00, bias=0x0001, sel=3 → with PSUM_SAT_EN: 0x7FFFFFFF, sat_flag=1; without: 0x80000000, sat_flag=0. Negative case: psum=0x80000000, bias=0xFFFF → 0x80000000 with flag (sat) or 0x7FFFFF00 (wrap).
- Backpressure: stream 5 beats with out_ready low for cycles 2-4 → no beat lost or duplicated, data held stable, in_ready=0 while stalled, in-order output.
- Write/read collision: write row 1 with 0x0002 while a bias beat reads row 1 (old value 0x0001) → output 0x00000100; the next read of row 1 gives 0x00000200.
- Reset mid-stream: assert rst with out_valid=1 and out_ready=0 → out_valid=0, ch_idx=0, and previously loaded rows read back as 0.
